// File: rtl/fml_txn_tracker.sv
// rtl/fml_txn_tracker.sv - instruction/memory transaction tracker emitting one retirement record per retire
module fml_txn_tracker #(
  parameter int INSN_DEPTH = 2,
  parameter int MEM_DEPTH  = 5,
  localparam int OW = $clog2(INSN_DEPTH + 1),
  localparam int CW = $clog2(MEM_DEPTH + 1)
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  input  logic                   cpu_insn_req,
  input  logic                   cop_insn_ack,
  input  logic [31:0]            cpu_insn_enc,
  input  logic [31:0]            cpu_rs1,
  input  logic [31:0]            cpu_rs2,
  input  logic                   cop_insn_rsp,
  input  logic                   cpu_insn_ack,
  input  logic                   cop_wen,
  input  logic [4:0]             cop_waddr,
  input  logic [31:0]            cop_wdata,
  input  logic [2:0]             cop_result,
  input  logic                   cop_mem_cen,
  input  logic                   cop_mem_wen,
  input  logic [31:0]            cop_mem_addr,
  input  logic [31:0]            cop_mem_wdata,
  input  logic [31:0]            cop_mem_rdata,
  input  logic [3:0]             cop_mem_ben,
  input  logic                   cop_mem_stall,
  input  logic                   cop_mem_error,
  output logic                   vtx_valid,
  output logic [31:0]            vtx_instr_enc,
  output logic [31:0]            vtx_instr_rs1,
  output logic [31:0]            vtx_instr_rs2,
  output logic [2:0]             vtx_instr_result,
  output logic                   vtx_instr_wen,
  output logic [4:0]             vtx_instr_waddr,
  output logic [31:0]            vtx_instr_wdata,
  output logic [CW-1:0]          vtx_mem_count,
  output logic [MEM_DEPTH-1:0]   vtx_mem_wen,
  output logic [4*MEM_DEPTH-1:0] vtx_mem_ben,
  output logic [32*MEM_DEPTH-1:0] vtx_mem_addr,
  output logic [32*MEM_DEPTH-1:0] vtx_mem_wdata,
  output logic [32*MEM_DEPTH-1:0] vtx_mem_rdata,
  output logic [MEM_DEPTH-1:0]   vtx_mem_error,
  output logic                   vtx_mem_ovf,
  output logic [OW-1:0]          vtx_outstanding,
  output logic [3:0]             vtx_proto_err
);

  localparam int PW = $clog2(INSN_DEPTH);

  logic [95:0]   fifo_q [INSN_DEPTH];
  logic [95:0]   fifo_d [INSN_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [3:0]    err_q, err_d;
  logic          hold_q, cen_prev_q;
  logic [31:0]   hold_enc_q, hold_rs1_q, hold_rs2_q;

  logic [MEM_DEPTH-1:0]    s_wen_q, s_wen_d, s_err_q, s_err_d;
  logic [4*MEM_DEPTH-1:0]  s_ben_q, s_ben_d;
  logic [32*MEM_DEPTH-1:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d, s_rdata_q, s_rdata_d;
  logic [CW-1:0]           mcnt_q, mcnt_d, pend_idx_q, pend_idx_d, wr_slot;
  logic                    ovf_q, ovf_d, pend_q, pend_d;

  logic [MEM_DEPTH-1:0]    snap_wen, snap_err;
  logic [4*MEM_DEPTH-1:0]  snap_ben;
  logic [32*MEM_DEPTH-1:0] snap_addr, snap_wdata, snap_rdata;

  logic        issue_hs, retire_hs, empty, full, push, pop, mem_acc, room, hold_viol;
  logic [95:0] head;

  assign issue_hs  = cpu_insn_req && cop_insn_ack;
  assign retire_hs = cop_insn_rsp && cpu_insn_ack;
  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OW'(INSN_DEPTH));
  assign pop       = retire_hs && !empty;
  assign push      = issue_hs && (!full || pop);
  assign head      = fifo_q[rd_ptr_q];
  assign mem_acc   = cop_mem_cen && !cop_mem_stall;
  assign wr_slot   = pop ? '0 : mcnt_q;
  assign room      = pop || (mcnt_q < CW'(MEM_DEPTH));
  assign hold_viol = hold_q && (!cpu_insn_req || (cpu_insn_enc != hold_enc_q) ||
                     (cpu_rs1 != hold_rs1_q) || (cpu_rs2 != hold_rs2_q));

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {cpu_insn_enc, cpu_rs1, cpu_rs2};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    err_d = err_q | {cop_mem_error && !cen_prev_q, hold_viol,
                     retire_hs && empty, issue_hs && full && !pop};
  end

  // A slot's read data lands one cycle after its accept; a retire in that
  // cycle takes the value straight from the bus.
  always_comb begin
    snap_wen   = '0;
    snap_err   = '0;
    snap_ben   = '0;
    snap_addr  = '0;
    snap_wdata = '0;
    snap_rdata = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (CW'(i) < mcnt_q) begin
        snap_wen[i]            = s_wen_q[i];
        snap_ben[4*i +: 4]     = s_ben_q[4*i +: 4];
        snap_addr[32*i +: 32]  = s_addr_q[32*i +: 32];
        snap_wdata[32*i +: 32] = s_wdata_q[32*i +: 32];
        if (pend_q && (pend_idx_q == CW'(i))) begin
          snap_rdata[32*i +: 32] = cop_mem_rdata;
          snap_err[i]            = cop_mem_error;
        end else begin
          snap_rdata[32*i +: 32] = s_rdata_q[32*i +: 32];
          snap_err[i]            = s_err_q[i];
        end
      end
    end
  end

  always_comb begin
    s_wen_d    = s_wen_q;
    s_err_d    = s_err_q;
    s_ben_d    = s_ben_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_rdata_d  = s_rdata_q;
    mcnt_d     = pop ? '0 : mcnt_q;
    ovf_d      = pop ? 1'b0 : ovf_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (pend_q && (pend_idx_q == CW'(i))) begin
        s_rdata_d[32*i +: 32] = cop_mem_rdata;
        s_err_d[i]            = cop_mem_error;
      end
    end
    if (mem_acc && room) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        if (wr_slot == CW'(i)) begin
          s_wen_d[i]            = cop_mem_wen;
          s_ben_d[4*i +: 4]     = cop_mem_ben;
          s_addr_d[32*i +: 32]  = cop_mem_addr;
          s_wdata_d[32*i +: 32] = cop_mem_wdata;
        end
      end
      mcnt_d     = wr_slot + 1'b1;
      pend_d     = 1'b1;
      pend_idx_d = wr_slot;
    end else if (mem_acc) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < INSN_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;  wr_ptr_q <= '0;  occ_q <= '0;  err_q <= '0;
      hold_q <= 1'b0;  cen_prev_q <= 1'b0;
      hold_enc_q <= '0;  hold_rs1_q <= '0;  hold_rs2_q <= '0;
      s_wen_q <= '0;  s_err_q <= '0;  s_ben_q <= '0;
      s_addr_q <= '0;  s_wdata_q <= '0;  s_rdata_q <= '0;
      mcnt_q <= '0;  ovf_q <= 1'b0;  pend_q <= 1'b0;  pend_idx_q <= '0;
      vtx_valid <= 1'b0;
      vtx_instr_enc <= '0;  vtx_instr_rs1 <= '0;  vtx_instr_rs2 <= '0;
      vtx_instr_result <= '0;  vtx_instr_wen <= 1'b0;
      vtx_instr_waddr <= '0;  vtx_instr_wdata <= '0;
      vtx_mem_count <= '0;  vtx_mem_wen <= '0;  vtx_mem_ben <= '0;
      vtx_mem_addr <= '0;  vtx_mem_wdata <= '0;  vtx_mem_rdata <= '0;
      vtx_mem_error <= '0;  vtx_mem_ovf <= 1'b0;
    end else begin
      fifo_q <= fifo_d;
      rd_ptr_q <= rd_ptr_d;  wr_ptr_q <= wr_ptr_d;  occ_q <= occ_d;  err_q <= err_d;
      hold_q <= cpu_insn_req && !cop_insn_ack;
      cen_prev_q <= cop_mem_cen;
      hold_enc_q <= cpu_insn_enc;  hold_rs1_q <= cpu_rs1;  hold_rs2_q <= cpu_rs2;
      s_wen_q <= s_wen_d;  s_err_q <= s_err_d;  s_ben_q <= s_ben_d;
      s_addr_q <= s_addr_d;  s_wdata_q <= s_wdata_d;  s_rdata_q <= s_rdata_d;
      mcnt_q <= mcnt_d;  ovf_q <= ovf_d;  pend_q <= pend_d;  pend_idx_q <= pend_idx_d;
      vtx_valid <= pop;
      if (pop) begin
        {vtx_instr_enc, vtx_instr_rs1, vtx_instr_rs2} <= head;
        vtx_instr_result <= cop_result;
        vtx_instr_wen    <= cop_wen;
        vtx_instr_waddr  <= cop_waddr;
        vtx_instr_wdata  <= cop_wdata;
        vtx_mem_count    <= mcnt_q;
        vtx_mem_wen      <= snap_wen;
        vtx_mem_ben      <= snap_ben;
        vtx_mem_addr     <= snap_addr;
        vtx_mem_wdata    <= snap_wdata;
        vtx_mem_rdata    <= snap_rdata;
        vtx_mem_error    <= snap_err;
        vtx_mem_ovf      <= ovf_q;
      end
    end
  end

  assign vtx_outstanding = occ_q;
  assign vtx_proto_err   = err_q;

endmodule

// File: tb/tb_fml_txn_tracker.sv
// tb/tb_fml_txn_tracker.sv - table vectors plus record scoreboard for fml_txn_tracker
`timescale 1ns/1ps
module tb_fml_txn_tracker;
  localparam int ID = 2;
  localparam int MD = 5;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  logic req, iack, rsp, rack, wen, mcen, mwen, mstall, merr;
  logic [31:0] enc, rs1, rs2, wdata, maddr, mwdata, mrdata;
  logic [4:0] waddr;
  logic [2:0] result;
  logic [3:0] mben;

  logic v_valid, v_wen, v_movf;
  logic [31:0] v_enc, v_rs1, v_rs2, v_wdata;
  logic [2:0] v_result, v_mcnt;
  logic [4:0] v_waddr, v_mwen, v_merr;
  logic [19:0] v_mben;
  logic [159:0] v_maddr, v_mwdata, v_mrdata;
  logic [1:0] v_out;
  logic [3:0] v_perr;

  fml_txn_tracker #(.INSN_DEPTH(ID), .MEM_DEPTH(MD)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpu_insn_req(req), .cop_insn_ack(iack), .cpu_insn_enc(enc), .cpu_rs1(rs1), .cpu_rs2(rs2),
    .cop_insn_rsp(rsp), .cpu_insn_ack(rack), .cop_wen(wen), .cop_waddr(waddr), .cop_wdata(wdata),
    .cop_result(result), .cop_mem_cen(mcen), .cop_mem_wen(mwen), .cop_mem_addr(maddr),
    .cop_mem_wdata(mwdata), .cop_mem_rdata(mrdata), .cop_mem_ben(mben), .cop_mem_stall(mstall),
    .cop_mem_error(merr),
    .vtx_valid(v_valid), .vtx_instr_enc(v_enc), .vtx_instr_rs1(v_rs1), .vtx_instr_rs2(v_rs2),
    .vtx_instr_result(v_result), .vtx_instr_wen(v_wen), .vtx_instr_waddr(v_waddr),
    .vtx_instr_wdata(v_wdata), .vtx_mem_count(v_mcnt), .vtx_mem_wen(v_mwen), .vtx_mem_ben(v_mben),
    .vtx_mem_addr(v_maddr), .vtx_mem_wdata(v_mwdata), .vtx_mem_rdata(v_mrdata),
    .vtx_mem_error(v_merr), .vtx_mem_ovf(v_movf), .vtx_outstanding(v_out), .vtx_proto_err(v_perr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] enc, rs1, rs2;
    logic [2:0] result;
    logic wen;
    logic [4:0] waddr;
    logic [31:0] wdata;
    logic [2:0] cnt;
    logic ovf;
    logic [4:0] mwen, merr;
    logic [19:0] mben;
    logic [159:0] maddr, mwdata, mrdata;
  } rec_t;
  rec_t exp_q[$];
  rec_t mon_e;

  logic [31:0] q_enc[$], q_rs1[$], q_rs2[$];
  int w_cnt;
  bit w_ovf, w_pend;
  logic w_wen[MD], w_err[MD];
  logic [3:0] w_ben[MD];
  logic [31:0] w_addr[MD], w_wdata[MD], w_rdata[MD];

  task automatic mreset();
    q_enc.delete(); q_rs1.delete(); q_rs2.delete(); exp_q.delete();
    w_cnt = 0; w_ovf = 0; w_pend = 0;
  endtask

  task automatic idle();
    req = 0; iack = 0; rsp = 0; rack = 0; enc = 0; rs1 = 0; rs2 = 0;
    wen = 0; waddr = 0; wdata = 0; result = 0;
    mcen = 0; mwen = 0; maddr = 0; mwdata = 0; mrdata = 0; mben = 0; mstall = 0; merr = 0;
  endtask

  task automatic set_insn(input logic [31:0] e);
    enc = e; rs1 = e ^ 32'h1111_1111; rs2 = e ^ 32'h2222_2222;
  endtask

  // Scoreboard model: runs on the values being driven, then advances one clock.
  task automatic tick();
    rec_t r;
    if (w_pend) begin
      w_rdata[w_cnt-1] = mrdata;
      w_err[w_cnt-1] = merr;
    end
    if (rsp && rack && q_enc.size() > 0) begin
      r = '0;
      r.enc = q_enc.pop_front(); r.rs1 = q_rs1.pop_front(); r.rs2 = q_rs2.pop_front();
      r.result = result; r.wen = wen; r.waddr = waddr; r.wdata = wdata;
      r.cnt = 3'(w_cnt); r.ovf = w_ovf;
      for (int i = 0; i < w_cnt; i++) begin
        r.mwen[i] = w_wen[i]; r.merr[i] = w_err[i]; r.mben[4*i +: 4] = w_ben[i];
        r.maddr[32*i +: 32] = w_addr[i]; r.mwdata[32*i +: 32] = w_wdata[i];
        r.mrdata[32*i +: 32] = w_rdata[i];
      end
      exp_q.push_back(r);
      w_cnt = 0; w_ovf = 0;
    end
    if (req && iack && q_enc.size() < ID) begin
      q_enc.push_back(enc); q_rs1.push_back(rs1); q_rs2.push_back(rs2);
    end
    w_pend = 0;
    if (mcen && !mstall) begin
      if (w_cnt < MD) begin
        w_wen[w_cnt] = mwen; w_ben[w_cnt] = mben; w_addr[w_cnt] = maddr;
        w_wdata[w_cnt] = mwdata; w_rdata[w_cnt] = 32'hx; w_err[w_cnt] = 1'bx;
        w_cnt++; w_pend = 1;
      end else begin
        w_ovf = 1;
      end
    end
    @(posedge g_clk); #1;
  endtask

  always @(negedge g_clk) begin
    if (g_resetn && v_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_record: got vtx_valid=1 (enc %h) expected no record", v_enc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rec_enc", 160'(v_enc), 160'(mon_e.enc));
        chk("rec_rs", 160'({v_rs1, v_rs2}), 160'({mon_e.rs1, mon_e.rs2}));
        chk("rec_wb", 160'({v_result, v_wen, v_waddr, v_wdata}),
            160'({mon_e.result, mon_e.wen, mon_e.waddr, mon_e.wdata}));
        chk("rec_cnt_ovf", 160'({v_mcnt, v_movf}), 160'({mon_e.cnt, mon_e.ovf}));
        chk("rec_wen_err_ben", 160'({v_mwen, v_merr, v_mben}), 160'({mon_e.mwen, mon_e.merr, mon_e.mben}));
        chk("rec_addr", v_maddr, mon_e.maddr);
        chk("rec_wdata", v_mwdata, mon_e.mwdata);
        chk("rec_rdata", v_mrdata, mon_e.mrdata);
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 160'(v_valid), 160'(0));
    chk({tag, "_out_err"}, 160'({v_out, v_perr}), 160'(0));
    chk({tag, "_rec"}, 160'(|{v_enc, v_rs1, v_rs2, v_result, v_wen, v_waddr, v_wdata, v_mcnt,
                              v_mwen, v_mben, v_maddr, v_mwdata, v_mrdata, v_merr, v_movf}), 160'(0));
  endtask

  task automatic do_reset();
    idle();
    g_resetn = 0;
    mreset();
    #1;
    chk_reset_outs("reset");
    @(posedge g_clk); #1;
    g_resetn = 1;
  endtask

  typedef struct {
    logic req, iack, rsp, rack;
    logic [31:0] enc;
    logic [1:0] eout;
    logic [3:0] eerr;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hA000_0001, 2'd1, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd1, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd1, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         2'd0, 4'b0000};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hB000_0001, 2'd1, 4'b0000};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hB000_0002, 2'd2, 4'b0000};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hB000_0003, 2'd2, 4'b0001};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         2'd1, 4'b0001};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         2'd0, 4'b0001};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         2'd0, 4'b0011};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 4'b0011};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hC000_0001, 2'd1, 4'b0011};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC000_0002, 2'd1, 4'b0011};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         2'd0, 4'b0011};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC000_0003, 2'd1, 4'b0011};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         2'd0, 4'b0011};

    idle();
    mreset();
    #12;
    chk_reset_outs("init");
    g_resetn = 1;

    // Queue behaviour: latency, overflow drop, in-order retire, empty retire.
    for (int i = 0; i < 16; i++) begin
      idle();
      req = tbl[i].req; iack = tbl[i].iack; rsp = tbl[i].rsp; rack = tbl[i].rack;
      set_insn(tbl[i].enc);
      wen = i[0]; waddr = 5'(i); wdata = 32'hC0DE_0000 + 32'(i); result = 3'(i);
      tick();
      chk($sformatf("tbl%0d_out", i), 160'(v_out), 160'(tbl[i].eout));
      chk($sformatf("tbl%0d_err", i), 160'(v_perr), 160'(tbl[i].eerr));
      if (tbl[i].rsp && tbl[i].eout != 2'd1 && i == 3)
        chk("tbl3_valid_latency", 160'(v_valid), 160'(1));
    end
    idle(); tick();
    chk("tbl_all_popped", 160'(exp_q.size()), 160'(0));

    do_reset();

    // Two accepts then retire.
    req = 1; iack = 1; set_insn(32'hD000_0001); tick(); idle();
    mcen = 1; mwen = 0; maddr = 32'h100; mben = 4'h3; tick();
    mwen = 1; maddr = 32'h104; mwdata = 32'hDEAD_BEEF; mben = 4'hF; mrdata = 32'h1111_0100; tick();
    mcen = 0; mwen = 0; maddr = 0; mwdata = 0; mben = 0; mrdata = 32'h2222_0104; tick();
    idle(); rsp = 1; rack = 1; result = 3'd5; wen = 1; waddr = 5'd7; wdata = 32'h7777; tick(); idle();
    chk("t3_cnt", 160'(v_mcnt), 160'(3'd2));
    chk("t3_slot0_addr", 160'(v_maddr[31:0]), 160'(32'h100));
    chk("t3_slot1_wen", 160'(v_mwen[1]), 160'(1));
    chk("t3_unused_zero", 160'(v_maddr[159:64]), 160'(0));
    tick();

    // Retire right after an accept, and an accept alongside a retire.
    req = 1; iack = 1; set_insn(32'hE000_0001); tick();
    set_insn(32'hE000_0002); mcen = 1; maddr = 32'h200; mben = 4'h1; tick(); idle();
    rsp = 1; rack = 1; mrdata = 32'h3333_0200; mcen = 1; maddr = 32'h300; mben = 4'h2; tick(); idle();
    chk("byp_cnt", 160'(v_mcnt), 160'(3'd1));
    chk("byp_rdata", 160'(v_mrdata[31:0]), 160'(32'h3333_0200));
    mrdata = 32'h4444_0300; merr = 1; tick(); idle();
    rsp = 1; rack = 1; tick(); idle();
    chk("next_win_addr", 160'(v_maddr[31:0]), 160'(32'h300));
    chk("next_win_err", 160'({v_mcnt, v_merr}), 160'({3'd1, 5'b00001}));
    tick();

    // Window overflow, then a clean window.
    req = 1; iack = 1; set_insn(32'hF000_0001); tick();
    set_insn(32'hF000_0002); tick(); idle();
    for (int k = 0; k < 6; k++) begin
      mcen = 1; mwen = k[0]; maddr = 32'h400 + 32'(4*k); mwdata = 32'(k); mben = 4'(k + 1);
      mrdata = 32'h5000_0000 + 32'(k); merr = (k == 2);
      tick();
    end
    idle(); mrdata = 32'h5000_0006; tick(); idle();
    rsp = 1; rack = 1; tick(); idle();
    chk("ovf_cnt", 160'(v_mcnt), 160'(3'd5));
    chk("ovf_flag", 160'(v_movf), 160'(1));
    mcen = 1; maddr = 32'h500; tick(); idle();
    mrdata = 32'h6000_0500; tick(); idle();
    rsp = 1; rack = 1; tick(); idle();
    chk("after_ovf", 160'({v_mcnt, v_movf}), 160'({3'd1, 1'b0}));
    tick();
    chk("mem_no_err", 160'({v_out, v_perr}), 160'(0));

    // Request hold violation and error-without-enable.
    req = 1; iack = 0; set_insn(32'h0000_1234); tick();
    chk("hold_first", 160'(v_perr), 160'(4'b0000));
    set_insn(32'h0000_5678); tick(); idle();
    chk("hold_changed", 160'(v_perr), 160'(4'b0100));
    tick();
    merr = 1; tick(); idle();
    chk("err_no_cen", 160'(v_perr), 160'(4'b1100));

    // Reset in the middle of a window, just as a record goes out.
    req = 1; iack = 1; set_insn(32'h9000_0001); tick();
    set_insn(32'h9000_0002); mcen = 1; maddr = 32'h600; tick(); idle();
    rsp = 1; rack = 1; mrdata = 32'h1; tick(); idle();
    chk("pre_rst_valid", 160'(v_valid), 160'(1));
    do_reset();
    rsp = 1; rack = 1; tick(); idle();
    chk("post_rst_empty", 160'({v_out, v_perr}), 160'({2'd0, 4'b0010}));
    req = 1; iack = 1; set_insn(32'h9100_0001); tick(); idle();
    rsp = 1; rack = 1; tick(); idle();
    chk("post_rst_cnt", 160'({v_valid, v_mcnt}), 160'({1'b1, 3'd0}));
    tick(); tick();
    chk("scoreboard_drained", 160'(exp_q.size()), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
